silife_vga_row_fetch: RTL
=========================

// Module: silife_vga_row_fetch
// PURPOSE
//  Upstream feeder for the VGA scan-out stage. Tracks the row being scanned
//  (row_select from the VGA stage) and presents that row's WIDTH cell bits on
//  o_cells. Rows are fetched from the shared cell-grid memory port over a
//  req/ack handshake. The next row is prefetched, so scan-out never waits on
//  memory arbitration with the life engine.
// PARAMETERS
//  WIDTH     32               cells per row (bits per fetch)
//  HEIGHT    32               rows in grid
//  ROW_BITS  $clog2(HEIGHT)   row index width
// PORTS
//  clk            in   1         single clock (pixel clock domain)
//  reset_n        in   1         asynchronous, active-low reset
//  i_enable       in   1         scan-out enable; low = blank, no new fetches
//  i_row_select   in   ROW_BITS  row currently scanned (from VGA stage)
//  o_cells        out  WIDTH     cells of current row (to VGA stage i_cells)
//  o_mem_req      out  1         fetch request to grid memory arbiter
//  o_mem_row      out  ROW_BITS  row address of request
//  i_mem_ack      in   1         grant+data valid; one-cycle pulse
//  i_mem_data     in   WIDTH     row data, valid when i_mem_ack=1
//  o_underrun     out  1         sticky: row change arrived before its data
//  i_clr_underrun in   1         synchronous clear of o_underrun
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - o_cells=0, o_mem_req=0, o_mem_row=0, o_underrun=0.
//   - cur_row_q=0, pf_valid=0, cur_valid=0, FSM=IDLE.
//  Row change: i_row_select != cur_row_q, sampled at the clk edge.
//   - Hit (pf_valid && pf_row==new row): disp<=pf data on that edge, so
//     o_cells updates 1 cycle after the change. Then pf_valid<=0 and a
//     prefetch of next row is queued.
//   - Miss: o_cells<=0, o_underrun<=1, demand fetch of new row queued.
//  Next-row arithmetic: HEIGHT-1 wraps to 0. Rows >= HEIGHT (non-pow2 HEIGHT):
//   o_cells=0, no fetch, no underrun.
//  FSM states:
//   - IDLE -> REQ when a demand or prefetch is pending. Demand has priority.
//   - REQ: o_mem_req=1; o_mem_row stays stable until ack.
//   - REQ -> IDLE on i_mem_ack. Data captured on the ack edge; o_mem_req drops
//     the following cycle.
//   - i_mem_ack in the first REQ cycle is legal. i_mem_ack while req=0 is
//     ignored.
//  Req is never withdrawn once raised. Returned data is routed by row:
//   - == cur_row_q: to disp.
//   - == cur_row_q+1 (wrapped): to pf, pf_valid<=1.
//   - else: discarded.
//   After the ack, whatever is still missing is re-requested.
//  Row change on the same edge as ack: routing compares against the new row.
//  After disp is filled: prefetch of next row issues automatically.
//  i_enable=0:
//   - o_cells=0 next cycle; pf_valid<=0; no new requests.
//   - An outstanding request completes and its data is discarded.
//   - Re-enable is treated as a row change (demand fetch, no underrun flag).
//  Underrun clear: i_clr_underrun clears o_underrun. If a new underrun occurs
//   on the same edge, set wins.
//  Reset asserted mid-request: o_mem_req drops immediately (async). The
//   arbiter must tolerate this.
// STRUCTURE
//  Shared include silife_vga_defs.vh:
//   - FSM state encodings (IDLE, REQ).
//   - silife_next_row(row,HEIGHT) wrap function.
//   - Default WIDTH/HEIGHT, also used by silife_vga and the grid.
//  Single module, no sub-module. The req/ack port is small enough to stay
//  inline.
//  Registers: cur_row_q, disp_q, pf_q, pf_row_q, pf_valid_q, req_row_q,
//   state_q, underrun_q.
// TESTING
//  1 Reset, enable=1, row=0, ack 3 cycles after req:
//    fetch row0 -> o_cells=data0 -> auto req row1 -> pf_valid.
//  2 Row 0->1 after prefetch done: o_cells=data1 exactly 1 cycle later;
//    o_underrun stays 0; req row2 issued.
//  3 Row 31->0 (HEIGHT=32): prefetch targets row 0 (wrap); hit, no underrun.
//  4 Arbiter withholds ack 2000 cycles across row change 4->5:
//    o_cells=0, o_underrun=1; ack returns row5 data -> o_cells=data5.
//  5 Row changes 6->7 on the same edge as ack of row7 prefetch:
//    o_cells=data7, no underrun.
//  6 enable=0 while req pending: req held until ack, data dropped,
//    o_cells=0; enable=1 -> demand fetch; reset_n low mid-req -> all outputs 0.

Source files
------------

// File: rtl/silife_vga_row_fetch_pkg.sv
// Shared definitions for the VGA row feeder: FSM encodings, grid defaults
// and the wrapping next-row helper.
package silife_vga_row_fetch_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_HEIGHT = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    // Row after 'row'; the last row of the grid wraps back to row 0.
    function automatic int silife_next_row(input int row, input int height);
        return (row >= height - 1) ? 0 : row + 1;
    endfunction

endpackage

// File: rtl/silife_vga_row_fetch.sv
// Presents the currently scanned row's cells to the VGA stage, fetching rows
// over a req/ack port and prefetching the next row so scan-out never stalls.
module silife_vga_row_fetch
    import silife_vga_row_fetch_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int ROW_BITS = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_enable,
    input  logic [ROW_BITS-1:0] i_row_select,
    output logic [WIDTH-1:0]    o_cells,
    output logic                o_mem_req,
    output logic [ROW_BITS-1:0] o_mem_row,
    input  logic                i_mem_ack,
    input  logic [WIDTH-1:0]    i_mem_data,
    output logic                o_underrun,
    input  logic                i_clr_underrun
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_d;
    logic [ROW_BITS-1:0] r_req_row;
    logic [ROW_BITS-1:0] w_req_row_d;

    logic [ROW_BITS-1:0] r_cur_row;
    logic                r_cur_valid;
    logic [WIDTH-1:0]    r_disp;
    logic [WIDTH-1:0]    r_pf;
    logic [ROW_BITS-1:0] r_pf_row;
    logic                r_pf_valid;
    logic                r_underrun;
    logic                r_en_q;

    logic [WIDTH-1:0]    w_disp_d;
    logic                w_cur_valid_d;
    logic [WIDTH-1:0]    w_pf_d;
    logic [ROW_BITS-1:0] w_pf_row_d;
    logic                w_pf_valid_d;
    logic                w_underrun_set;

    logic                w_ack;
    logic                w_en_rise;
    logic                w_chg;
    logic [ROW_BITS-1:0] w_new_row;
    logic [ROW_BITS-1:0] w_new_next;
    logic [ROW_BITS-1:0] w_cur_next;
    logic                w_in_range;
    logic                w_cur_in_range;
    logic                w_pf_hit;
    logic                w_ack_cur;
    logic                w_ack_nxt;
    logic                w_demand;
    logic                w_pf_need;

    // A rising enable counts as a row change so the row is demand-fetched.
    assign w_ack          = i_mem_ack && (r_state == ST_REQ);
    assign w_en_rise      = i_enable && !r_en_q;
    assign w_chg          = i_enable && ((i_row_select != r_cur_row) || w_en_rise);
    assign w_new_row      = i_enable ? i_row_select : r_cur_row;
    assign w_new_next     = ROW_BITS'(silife_next_row(int'(w_new_row), HEIGHT));
    assign w_cur_next     = ROW_BITS'(silife_next_row(int'(r_cur_row), HEIGHT));
    assign w_in_range     = (int'(w_new_row) < HEIGHT);
    assign w_cur_in_range = (int'(r_cur_row) < HEIGHT);
    assign w_pf_hit       = r_pf_valid && (r_pf_row == w_new_row);

    // Returned data is routed against the row as it stands after this edge.
    assign w_ack_cur = w_ack && w_in_range && (r_req_row == w_new_row);
    assign w_ack_nxt = w_ack && w_in_range && (r_req_row == w_new_next);

    assign w_demand  = i_enable && r_en_q && !w_chg && w_cur_in_range && !r_cur_valid;
    assign w_pf_need = i_enable && !w_chg && r_cur_valid && !r_pf_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_req_row <= '0;
        end else begin
            r_state   <= w_state_d;
            r_req_row <= w_req_row_d;
        end
    end

    // A raised request is held until acked; demand beats prefetch.
    always_comb begin
        w_state_d   = r_state;
        w_req_row_d = r_req_row;
        case (r_state)
            ST_IDLE: begin
                if (w_demand) begin
                    w_state_d   = ST_REQ;
                    w_req_row_d = r_cur_row;
                end else if (w_pf_need) begin
                    w_state_d   = ST_REQ;
                    w_req_row_d = w_cur_next;
                end
            end
            ST_REQ: begin
                if (w_ack) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_req = (r_state == ST_REQ);
        o_mem_row = r_req_row;
    end

    always_comb begin
        w_disp_d       = r_disp;
        w_cur_valid_d  = r_cur_valid;
        w_pf_d         = r_pf;
        w_pf_row_d     = r_pf_row;
        w_pf_valid_d   = r_pf_valid;
        w_underrun_set = 1'b0;
        if (!i_enable) begin
            w_disp_d      = '0;
            w_cur_valid_d = 1'b0;
            w_pf_valid_d  = 1'b0;
        end else begin
            if (w_chg) begin
                if (!w_in_range) begin
                    w_disp_d      = '0;
                    w_cur_valid_d = 1'b0;
                end else if (w_pf_hit) begin
                    w_disp_d      = r_pf;
                    w_cur_valid_d = 1'b1;
                end else if (w_ack_cur) begin
                    w_disp_d      = i_mem_data;
                    w_cur_valid_d = 1'b1;
                end else begin
                    w_disp_d       = '0;
                    w_cur_valid_d  = 1'b0;
                    w_underrun_set = !w_en_rise;
                end
            end else if (w_ack_cur) begin
                w_disp_d      = i_mem_data;
                w_cur_valid_d = 1'b1;
            end

            if (w_ack_nxt) begin
                w_pf_d       = i_mem_data;
                w_pf_row_d   = r_req_row;
                w_pf_valid_d = 1'b1;
            end else if (w_chg) begin
                w_pf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_row   <= '0;
            r_cur_valid <= 1'b0;
            r_disp      <= '0;
            r_pf        <= '0;
            r_pf_row    <= '0;
            r_pf_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_en_q      <= 1'b0;
        end else begin
            r_cur_row   <= w_new_row;
            r_cur_valid <= w_cur_valid_d;
            r_disp      <= w_disp_d;
            r_pf        <= w_pf_d;
            r_pf_row    <= w_pf_row_d;
            r_pf_valid  <= w_pf_valid_d;
            r_en_q      <= i_enable;
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (i_clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign o_cells    = r_disp;
    assign o_underrun = r_underrun;

endmodule
